// File: rtl/pcecd_pkg.sv
// Shared constants for the PCE CD initiator bus engine:
// bus phase codes, CDC_STAT bit masks, error codes and FSM states.
package pcecd_pkg;

    localparam logic [2:0] PHASE_BUS_FREE    = 3'd0;
    localparam logic [2:0] PHASE_COMMAND     = 3'd1;
    localparam logic [2:0] PHASE_DATA_IN     = 3'd2;
    localparam logic [2:0] PHASE_DATA_OUT    = 3'd3;
    localparam logic [2:0] PHASE_STATUS      = 3'd4;
    localparam logic [2:0] PHASE_MESSAGE_IN  = 3'd5;
    localparam logic [2:0] PHASE_MESSAGE_OUT = 3'd6;

    localparam logic [7:0] CDC_STAT_BUSY = 8'h80;
    localparam logic [7:0] CDC_STAT_REQ  = 8'h40;
    localparam logic [7:0] CDC_STAT_MSG  = 8'h20;
    localparam logic [7:0] CDC_STAT_CD   = 8'h10;
    localparam logic [7:0] CDC_STAT_IO   = 8'h08;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_SEL_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_CMD_OVERRUN = 3'd2;
    localparam logic [2:0] ERR_DATA_OUT    = 3'd3;
    localparam logic [2:0] ERR_BUS_FREE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT_REQ,
        ST_SETUP,
        ST_ACK_HIGH,
        ST_WAIT_REQ_LOW,
        ST_BUS_RST
    } state_t;

endpackage

// File: rtl/pcecd_phase_decode.sv
// Maps the target-driven BSY/MSG/CD/IO lines to a bus phase code.
module pcecd_phase_decode
    import pcecd_pkg::*;
(
    input  logic       bsy,
    input  logic       msg,
    input  logic       cd,
    input  logic       io,
    output logic [2:0] phase
);

    always_comb begin
        phase = PHASE_BUS_FREE;
        if (bsy) begin
            case ({msg, cd, io})
                3'b010:  phase = PHASE_COMMAND;
                3'b001:  phase = PHASE_DATA_IN;
                3'b011:  phase = PHASE_STATUS;
                3'b111:  phase = PHASE_MESSAGE_IN;
                3'b110:  phase = PHASE_MESSAGE_OUT;
                default: phase = PHASE_DATA_OUT;
            endcase
        end
    end

endmodule

// File: rtl/pcecd_scsi_initiator.sv
// Initiator end of the CD drive link: selection, command out,
// data-in streaming, status/message capture and host bus reset.
module pcecd_scsi_initiator
    import pcecd_pkg::*;
#(
    parameter int CMD_MAX_BYTES = 10,
    parameter int SEL_TIMEOUT   = 1024,
    parameter int RST_CYCLES    = 16,
    parameter int DB_SETUP      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_wr,
    input  logic [3:0] cmd_waddr,
    input  logic [7:0] cmd_wdata,
    input  logic [3:0] cmd_len,
    input  logic       cmd_start,
    input  logic       bus_reset,
    input  logic       bsy_i,
    input  logic       req_i,
    input  logic       msg_i,
    input  logic       cd_i,
    input  logic       io_i,
    input  logic [7:0] db_i,
    output logic [7:0] db_o,
    output logic       db_oe,
    output logic       sel_o,
    output logic       ack_o,
    output logic       rst_o,
    output logic       din_valid,
    output logic [7:0] din_data,
    input  logic       din_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] status_byte,
    output logic [7:0] message_byte,
    output logic [2:0] err
);

    localparam int STW = $clog2(SEL_TIMEOUT + 1);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int SUW = $clog2(DB_SETUP + 1);
    localparam logic [STW-1:0] SEL_LAST   = STW'(SEL_TIMEOUT - 1);
    localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_CYCLES);
    localparam logic [SUW-1:0] SETUP_LAST = SUW'(DB_SETUP - 1);
    localparam logic [3:0]     BUF_DEPTH  = 4'(CMD_MAX_BYTES);

    state_t         state;
    logic [7:0]     cmd_buf [CMD_MAX_BYTES];
    logic [3:0]     idx;
    logic [3:0]     len;
    logic           msg_got;
    logic [2:0]     phase;
    logic [2:0]     cur_phase;
    logic [STW-1:0] sel_cnt;
    logic [RCW-1:0] rst_cnt;
    logic [SUW-1:0] setup_cnt;
    logic           idx_ok;

    pcecd_phase_decode u_decode (
        .bsy   (bsy_i),
        .msg   (msg_i),
        .cd    (cd_i),
        .io    (io_i),
        .phase (phase)
    );

    assign idx_ok = (idx < len) && (idx < BUF_DEPTH);

    always_ff @(posedge clk) begin
        if (cmd_wr && !busy && cmd_waddr < BUF_DEPTH)
            cmd_buf[cmd_waddr] <= cmd_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            len          <= '0;
            msg_got      <= 1'b0;
            cur_phase    <= PHASE_BUS_FREE;
            sel_cnt      <= '0;
            rst_cnt      <= '0;
            setup_cnt    <= '0;
            db_o         <= '0;
            db_oe        <= 1'b0;
            sel_o        <= 1'b0;
            ack_o        <= 1'b0;
            rst_o        <= 1'b0;
            din_valid    <= 1'b0;
            din_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            status_byte  <= '0;
            message_byte <= '0;
            err          <= ERR_NONE;
        end else begin
            done <= 1'b0;
            if (bus_reset && state != ST_IDLE && state != ST_BUS_RST) begin
                sel_o     <= 1'b0;
                ack_o     <= 1'b0;
                db_oe     <= 1'b0;
                din_valid <= 1'b0;
                rst_cnt   <= '0;
                state     <= ST_BUS_RST;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_start) begin
                            err     <= ERR_NONE;
                            idx     <= '0;
                            len     <= cmd_len;
                            msg_got <= 1'b0;
                            sel_cnt <= '0;
                            busy    <= 1'b1;
                            sel_o   <= 1'b1;
                            state   <= ST_SELECT;
                        end else if (bus_reset) begin
                            busy    <= 1'b1;
                            rst_cnt <= '0;
                            state   <= ST_BUS_RST;
                        end
                    end
                    ST_SELECT: begin
                        if (bsy_i) begin
                            sel_o <= 1'b0;
                            state <= ST_WAIT_REQ;
                        end else if (sel_cnt == SEL_LAST) begin
                            sel_o <= 1'b0;
                            err   <= ERR_SEL_TIMEOUT;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            sel_cnt <= sel_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_REQ: begin
                        if (!bsy_i) begin
                            din_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            if (!msg_got)
                                err <= ERR_BUS_FREE;
                            state <= ST_IDLE;
                        end else if (din_valid) begin
                            // ACK is withheld until the host takes the byte
                            if (din_ready) begin
                                din_valid <= 1'b0;
                                state     <= ST_ACK_HIGH;
                            end
                        end else if (req_i) begin
                            cur_phase <= phase;
                            case (phase)
                                PHASE_COMMAND: begin
                                    db_o      <= idx_ok ? cmd_buf[idx] : 8'h00;
                                    db_oe     <= 1'b1;
                                    setup_cnt <= '0;
                                    if (!idx_ok)
                                        err <= ERR_CMD_OVERRUN;
                                    state <= ST_SETUP;
                                end
                                PHASE_DATA_IN: begin
                                    din_data  <= db_i;
                                    din_valid <= 1'b1;
                                end
                                PHASE_STATUS: begin
                                    status_byte <= db_i;
                                    state       <= ST_ACK_HIGH;
                                end
                                PHASE_MESSAGE_IN: begin
                                    message_byte <= db_i;
                                    msg_got      <= 1'b1;
                                    state        <= ST_ACK_HIGH;
                                end
                                default: begin
                                    err   <= ERR_DATA_OUT;
                                    db_o  <= 8'h00;
                                    db_oe <= 1'b1;
                                    state <= ST_ACK_HIGH;
                                end
                            endcase
                        end
                    end
                    ST_SETUP: begin
                        if (setup_cnt == SETUP_LAST)
                            state <= ST_ACK_HIGH;
                        else
                            setup_cnt <= setup_cnt + 1'b1;
                    end
                    ST_ACK_HIGH: begin
                        ack_o <= 1'b1;
                        state <= ST_WAIT_REQ_LOW;
                    end
                    ST_WAIT_REQ_LOW: begin
                        // bus free here is resolved on the next WAIT_REQ cycle
                        if (!bsy_i) begin
                            ack_o <= 1'b0;
                            db_oe <= 1'b0;
                            state <= ST_WAIT_REQ;
                        end else if (!req_i) begin
                            ack_o <= 1'b0;
                            db_oe <= 1'b0;
                            if (cur_phase == PHASE_COMMAND && idx != 4'hF)
                                idx <= idx + 1'b1;
                            state <= ST_WAIT_REQ;
                        end
                    end
                    ST_BUS_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            rst_o <= 1'b0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            rst_o   <= 1'b1;
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
